// File: rtl/canvas_streamer.sv
// canvas_streamer: row-major valid/ready serialiser of the canvas, optional saturation via CANVAS_STREAMER_CLAMP_EN
module canvas_streamer #(
  parameter int WIDTH   = 28,
  parameter int HEIGHT  = 28,
  parameter int DATA_W  = 16,
  parameter int MAX_VAL = 2047
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [WIDTH-1:0][HEIGHT-1:0][DATA_W-1:0] canvas,
  output logic [DATA_W-1:0]                      pixel_data,
  output logic [9:0]                             pixel_addr,
  output logic                                   pixel_valid,
  input  logic                                   pixel_ready,
  output logic                                   pixel_last,
  output logic                                   busy,
  output logic                                   done
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int N = WIDTH * HEIGHT;
`ifdef CANVAS_STREAMER_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam logic [DATA_W-1:0] CEIL = DATA_W'(MAX_VAL);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic x_end, xfer;
  function automatic logic [DATA_W-1:0] sat(input logic [DATA_W-1:0] v);
    return (CLAMP && v > CEIL) ? CEIL : v;
  endfunction
  // Next scan position: x wraps at the row end and carries into y
  always_comb begin
    x_end = x == XW'(WIDTH - 1);
    x_nxt = x_end ? '0 : x + 1'b1;
    y_nxt = x_end ? y + 1'b1 : y;
    xfer  = pixel_valid && pixel_ready;
  end
  // Scan controller: FSM, scan position and the registered pixel output held across stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pixel_data  <= '0;
      pixel_addr  <= '0;
      pixel_valid <= 1'b0;
      pixel_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= STREAM;
          x           <= '0;
          y           <= '0;
          pixel_data  <= sat(canvas[0][0]);
          pixel_addr  <= '0;
          pixel_valid <= 1'b1;
          pixel_last  <= N == 1;
          busy        <= 1'b1;
        end
        STREAM: if (xfer) begin
          if (pixel_last) begin
            state       <= DONE;
            pixel_valid <= 1'b0;
            pixel_last  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            pixel_data <= sat(canvas[x_nxt][y_nxt]);
            pixel_addr <= pixel_addr + 10'd1;
            pixel_last <= pixel_addr == 10'(N - 2);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          x     <= '0;
          y     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_canvas_streamer.sv
// tb_canvas_streamer: randomized scoreboard bench for canvas_streamer
module tb_canvas_streamer;
  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;
  localparam int MAXV = 2047;
  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic pixel_ready = 0;
  logic [W-1:0][H-1:0][15:0] canvas;
  logic [15:0] pixel_data;
  logic [9:0]  pixel_addr;
  logic pixel_valid, pixel_last, busy, done;
  logic [15:0] cv [W][H];
  exp_t q[$];
  exp_t e;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0;
  int xfers = 0;
  int start_edge = 0;
  int done_edge = 0;
  int ready_mode = 0;
  bit lat_check = 0;
  bit stall = 0;
  logic [15:0] hold_data, seen89;
  logic [9:0]  hold_addr;

  canvas_streamer dut (
    .clk(clk), .rst(rst), .start(start), .canvas(canvas),
    .pixel_data(pixel_data), .pixel_addr(pixel_addr), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_last(pixel_last), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(posedge clk);
    #1 pixel_ready = (ready_mode == 0) ? 1'b1 : ($urandom % 2 == 1);
  end

  function automatic logic [15:0] clampf(input logic [15:0] v);
`ifdef CANVAS_STREAMER_CLAMP_EN
    return (v > 16'(MAXV)) ? 16'(MAXV) : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        canvas[x][y] = cv[x][y];
  endtask

  task automatic do_start();
    exp_t t;
    @(posedge clk);
    #1 start = 1;
    start_edge = cyc + 1;
    xfers = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        t.addr = y * W + x;
        t.data = clampf(cv[x][y]);
        q.push_back(t);
      end
    @(posedge clk);
    #1 start = 0;
    chk("start_busy", busy, 1);
    chk("start_valid", pixel_valid, 1);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 6000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("xfer_count", xfers, N);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic wait_addr(input int a);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(pixel_valid && pixel_addr == 10'(a)) && t < 6000);
    chk("reach_addr", pixel_addr, a);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability and done
  always @(negedge clk) if (!rst) begin
    if (stall) begin
      chk("hold_valid", pixel_valid, 1);
      chk("hold_addr", pixel_addr, hold_addr);
      chk("hold_data", pixel_data, hold_data);
    end
    stall = 0;
    if (pixel_valid) begin
      if (pixel_ready) begin
        if (q.size() == 0) chk("xfer_with_empty_queue", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("addr", pixel_addr, e.addr);
          chk("data", pixel_data, e.data);
          chk("last", pixel_last, e.addr == N - 1);
          if (e.addr == 89) seen89 = pixel_data;
          xfers++;
        end
      end else begin
        stall = 1;
        hold_addr = pixel_addr;
        hold_data = pixel_data;
      end
    end
    if (done) begin
      done_cnt++;
      done_edge = cyc;
      chk("done_q_empty", q.size(), 0);
      chk("done_busy", busy, 0);
      chk("done_valid", pixel_valid, 0);
      if (lat_check) chk("latency", done_edge - start_edge + 1, 785);
    end
  end

  initial begin
    int d0, t;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        cv[x][y] = 16'(y * W + x);
    pack();
    #12;
    chk("rst_data", pixel_data, 0);
    chk("rst_addr", pixel_addr, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_last", pixel_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    // ramp canvas, ready always high, latency check
    ready_mode = 0;
    lat_check = 1;
    d0 = done_cnt;
    do_start();
    wait_done(d0);
    lat_check = 0;
    // random canvas, random back-pressure, mutate the held pixel during a stall
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        cv[x][y] = 16'($urandom_range(0, 65535));
    pack();
    ready_mode = 1;
    d0 = done_cnt;
    do_start();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(pixel_valid && !pixel_ready && pixel_addr >= 50) && t < 6000);
    chk("stall_found", pixel_valid && !pixel_ready, 1);
    #1 cv[pixel_addr % W][pixel_addr / W] = ~cv[pixel_addr % W][pixel_addr / W];
    pack();
    wait_done(d0);
    // start pulses while busy are ignored
    ready_mode = 0;
    lat_check = 1;
    d0 = done_cnt;
    do_start();
    wait_addr(100);
    #1 start = 1;
    @(negedge clk);
    start = 0;
    wait_addr(500);
    #1 start = 1;
    @(negedge clk);
    start = 0;
    wait_done(d0);
    lat_check = 0;
    // saturation probe at canvas[5][3] (addr 89)
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        cv[x][y] = 16'($urandom_range(0, 65535));
    cv[5][3] = 16'd4000;
    pack();
    d0 = done_cnt;
    do_start();
    wait_done(d0);
`ifdef CANVAS_STREAMER_CLAMP_EN
    chk("addr89_value", seen89, 2047);
`else
    chk("addr89_value", seen89, 4000);
`endif
    // asynchronous reset mid-stream abandons it without done
    d0 = done_cnt;
    do_start();
    wait_addr(300);
    #2 rst = 1;
    #1;
    chk("arst_data", pixel_data, 0);
    chk("arst_addr", pixel_addr, 0);
    chk("arst_valid", pixel_valid, 0);
    chk("arst_last", pixel_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    q.delete();
    stall = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("idle_after_abort", busy, 0);
    // restart from address 0 under random back-pressure
    ready_mode = 1;
    d0 = done_cnt;
    do_start();
    wait_done(d0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
